// File: rtl/path_result_writer_if.sv
// Bus bundle between the DFS search datapath, path_result_writer and the
// result memory.
//   search side : start, wpathmin, node_vld, node_ptr, node_last
//   memory side : mem_addr, mem_wdata, mem_we (out), mem_ready (in)
//   status      : busy, done, err_ovf
// slave  = the writer block, master = whoever drives the search/memory side.
interface path_result_writer_if #(
  parameter int AW = 18,
  parameter int WW = 15
);
  logic          start;
  logic [WW-1:0] wpathmin;
  logic          node_vld;
  logic [AW-1:0] node_ptr;
  logic          node_last;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_ready;
  logic          busy;
  logic          done;
  logic          err_ovf;

  modport slave (
    input  start, wpathmin, node_vld, node_ptr, node_last, mem_ready,
    output mem_addr, mem_wdata, mem_we, busy, done, err_ovf
  );

  modport master (
    output start, wpathmin, node_vld, node_ptr, node_last, mem_ready,
    input  mem_addr, mem_wdata, mem_we, busy, done, err_ovf
  );
endinterface

// File: rtl/path_result_writer.sv
// path_result_writer: captures the minimum path weight and the serialized
// node-pointer stream from the DFS search, then writes one result record
//   BASE+0 : weight (zero-extended)
//   BASE+1 : node count
//   BASE+2+i : node pointer i (root first)
// through a valid/ready write port and pulses done once the record is written.
// Ports: clk, rst (sync, active-high), bus (path_result_writer_if.slave).
module path_result_writer #(
  parameter int D    = 8,
  parameter int AW   = 18,
  parameter int WW   = 15,
  parameter int BASE = 0
) (
  input  logic clk,
  input  logic rst,
  path_result_writer_if.slave bus
);
  localparam int CW = $clog2(D + 1);
  localparam int IW = $clog2(D);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  typedef enum logic [2:0] {IDLE, COLLECT, WR_HDR, WR_CNT, WR_PATH, FIN} st_t;

  st_t                  st, st_nx;
  logic [CW-1:0]        cnt, idx;
  logic [WW-1:0]        wgt;
  logic [D-1:0][AW-1:0] ptr_buf;
  logic                 ovf;

  logic                 we, dn;
  logic [AW-1:0]        addr, wdata;

  // Write states hold mem_we=1, so mem_ready alone marks acceptance there.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= '0;
      idx <= '0;
      wgt <= '0;
      ovf <= 1'b0;
    end else begin
      st <= st_nx;
      case (st)
        IDLE: if (bus.start) begin
          wgt <= bus.wpathmin;
          cnt <= '0;
          ovf <= 1'b0;
        end
        COLLECT: if (bus.node_vld) begin
          if (cnt < CW'(D)) begin
            ptr_buf[cnt[IW-1:0]] <= bus.node_ptr;
            cnt                  <= cnt + CW'(1);
          end else begin
            ovf <= 1'b1;
          end
        end
        WR_CNT:  if (bus.mem_ready) idx <= '0;
        WR_PATH: if (bus.mem_ready && idx != cnt - CW'(1)) idx <= idx + CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nx = st;
    we    = 1'b0;
    dn    = 1'b0;
    addr  = '0;
    wdata = '0;
    case (st)
      IDLE:    if (bus.start) st_nx = COLLECT;
      COLLECT: if (bus.node_last) st_nx = WR_HDR;
      WR_HDR: begin
        we    = 1'b1;
        addr  = BASE_A;
        wdata = {{(AW-WW){1'b0}}, wgt};
        if (bus.mem_ready) st_nx = WR_CNT;
      end
      WR_CNT: begin
        we    = 1'b1;
        addr  = BASE_A + AW'(1);
        wdata = {{(AW-CW){1'b0}}, cnt};
        if (bus.mem_ready) st_nx = (cnt == '0) ? FIN : WR_PATH;
      end
      WR_PATH: begin
        we    = 1'b1;
        // modulo-2^AW address wrap is intended
        addr  = BASE_A + AW'(2) + {{(AW-CW){1'b0}}, idx};
        wdata = ptr_buf[idx[IW-1:0]];
        if (bus.mem_ready && idx == cnt - CW'(1)) st_nx = FIN;
      end
      FIN: begin
        dn    = 1'b1;
        st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.done      = dn;
  assign bus.busy      = (st != IDLE);
  assign bus.err_ovf   = ovf;
endmodule

// File: tb/tb_path_result_writer.sv
module tb_path_result_writer;
  localparam int D = 8, AW = 18, WW = 15, BASE = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  path_result_writer_if #(.AW(AW), .WW(WW)) bus();
  path_result_writer #(.D(D), .AW(AW), .WW(WW), .BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, last_acc = -10, n_done = 0, we_cyc = 0;
  bit seen_done = 0;
  int rdy_mode = 0;   // 0 high, 1 toggle, 2 random, 4 low
  logic [AW-1:0] pq[$];
  wr_t act_q[$], exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory-side monitor: records accepted writes, checks stall stability
  // and done latency
  logic          pstall = 1'b0;
  logic [AW-1:0] paddr, pdata;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      we_cyc++;
      if (pstall) begin
        chk("stall_addr", 32'(bus.mem_addr), 32'(paddr));
        chk("stall_data", 32'(bus.mem_wdata), 32'(pdata));
      end
      if (bus.mem_ready) begin
        act_q.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
        last_acc = cyc;
      end
    end
    pstall = (bus.mem_we === 1'b1) && !bus.mem_ready;
    paddr  = bus.mem_addr;
    pdata  = bus.mem_wdata;
    if (bus.done === 1'b1) begin
      n_done++;
      seen_done = 1'b1;
      chk("done_lat", 32'(cyc), 32'(last_acc + 1));
    end
  end

  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.mem_ready = 1'b1;
        1: bus.mem_ready = ~bus.mem_ready;
        2: bus.mem_ready = 1'($urandom_range(0, 1));
        default: bus.mem_ready = 1'b0;
      endcase
    end
  end

  // reference record: header, count, then up to D pointers in order
  task automatic build_exp(input logic [WW-1:0] w);
    int n;
    n = (pq.size() > D) ? D : pq.size();
    exp_q.delete();
    exp_q.push_back('{a: AW'(BASE), d: AW'(w)});
    exp_q.push_back('{a: AW'(BASE + 1), d: AW'(n)});
    for (int i = 0; i < n; i++) exp_q.push_back('{a: AW'(BASE + 2 + i), d: pq[i]});
  endtask

  task automatic send(input logic [WW-1:0] w, input bit last_alone, input bit xs_col);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.wpathmin = w;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wpathmin = WW'($urandom);
    chk("ovf_clr", 32'(bus.err_ovf), 0);
    chk("busy_col", 32'(bus.busy), 1);
    if (xs_col) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int i = 0; i < pq.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      bus.node_vld  = 1'b1;
      bus.node_ptr  = pq[i];
      bus.node_last = (i == pq.size() - 1) && !last_alone;
      @(posedge clk); #1;
      bus.node_vld  = 1'b0;
      bus.node_last = 1'b0;
      bus.node_ptr  = AW'($urandom);
    end
    if (last_alone || pq.size() == 0) begin
      bus.node_last = 1'b1;
      @(posedge clk); #1;
      bus.node_last = 1'b0;
    end
    chk("ovf", 32'(bus.err_ovf), 32'(pq.size() > D));
  endtask

  task automatic run(input logic [WW-1:0] w, input bit last_alone, input bit xs_col,
                     input bit xs_path);
    int t, n;
    n = (pq.size() > D) ? D : pq.size();
    act_q.delete();
    seen_done = 1'b0; n_done = 0; we_cyc = 0;
    build_exp(w);
    send(w, last_alone, xs_col);
    if (xs_path) begin
      t = 0;
      while (!(bus.mem_we === 1'b1 && bus.mem_addr == AW'(BASE + 2)) && t < 200) begin
        @(negedge clk); t++;
      end
      chk("wrpath_to", 32'(t < 200), 1);
      @(posedge clk); #1; bus.start = 1'b1; bus.wpathmin = WW'($urandom);
      @(posedge clk); #1; bus.start = 1'b0;
    end
    t = 0;
    while (!seen_done && t < 400) begin
      @(negedge clk); t++;
    end
    chk("done_to", 32'(seen_done), 1);
    @(negedge clk);
    chk("busy_end", 32'(bus.busy), 0);
    chk("done_cnt", 32'(n_done), 1);
    chk("ovf_hold", 32'(bus.err_ovf), 32'(pq.size() > D));
    chk("nwr", 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        chk($sformatf("addr%0d", i), 32'(act_q[i].a), 32'(exp_q[i].a));
        chk($sformatf("data%0d", i), 32'(act_q[i].d), 32'(exp_q[i].d));
      end
    end
    if (rdy_mode == 0) chk("we_cyc", 32'(we_cyc), 32'(n + 2));
  endtask

  initial begin
    int t;
    rst = 1'b1;
    bus.start = 1'b0; bus.wpathmin = '0;
    bus.node_vld = 1'b0; bus.node_ptr = '0; bus.node_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",    32'(bus.mem_we), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_ovf",   32'(bus.err_ovf), 0);
    chk("rst_addr",  32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    rst = 1'b0;

    // basic three-node path, ready held high
    rdy_mode = 0;
    pq = '{18'd5, 18'd12, 18'd40};
    run(15'd37, 0, 0, 0);

    // same with ready toggling
    rdy_mode = 1;
    run(15'd37, 0, 0, 0);

    // empty path, no-path weight
    rdy_mode = 0;
    pq.delete();
    run(15'h7FFF, 1, 0, 0);

    // overflow: 10 pointers into an 8-deep buffer
    pq.delete();
    for (int i = 1; i <= 10; i++) pq.push_back(AW'(i));
    run(15'd99, 0, 0, 0);

    // stray start pulses in COLLECT and WR_PATH
    rdy_mode = 1;
    pq.delete();
    for (int i = 0; i < 5; i++) pq.push_back(AW'($urandom));
    run(15'd100, 0, 1, 1);

    // reset mid-WR_PATH while stalled
    rdy_mode = 0;
    pq = '{18'd5, 18'd12, 18'd40};
    act_q.delete();
    send(15'd37, 0, 0);
    t = 0;
    while (act_q.size() < 3 && t < 100) begin
      @(negedge clk); t++;
    end
    chk("rst_wait_to", 32'(t < 100), 1);
    @(posedge clk); #1;
    rdy_mode = 4; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_we",   32'(bus.mem_we), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    chk("mrst_addr", 32'(bus.mem_addr), 0);
    rst = 1'b0;
    rdy_mode = 0;
    run(15'd37, 0, 0, 0);

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      int n;
      rdy_mode = $urandom_range(0, 2);
      n = $urandom_range(0, 10);
      pq.delete();
      for (int i = 0; i < n; i++) pq.push_back(AW'($urandom));
      run(WW'($urandom), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/path_result_writer.md
Name: path_result_writer

Overview:
- Downstream of the DFS search datapath.
- Captures the minimum path weight and the serialized stream of path node pointers that the search emits once it finishes.
- Buffers up to D pointers, then writes one result record (weight, node count, pointers) into result memory through a valid/ready write port.
- Raises a one-cycle done when the record is fully written.

Parameters:
D, 8, maximum path depth, i.e. maximum number of buffered node pointers
AW, 18, node pointer and memory address/data width
WW, 15, path weight width (WW < AW)
BASE, 0, result record base address in result memory

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
start  input  1  one-cycle pulse: search finished; latches wpathmin
wpathmin  input  WW  minimum path weight from search datapath
node_vld  input  1  node_ptr valid this cycle
node_ptr  input  AW  path node pointer, root first
node_last  input  1  end of pointer stream; may coincide with node_vld
mem_addr  output  AW  result memory write address
mem_wdata  output  AW  result memory write data
mem_we  output  1  write request; held until accepted
mem_ready  input  1  memory accepts the write at this posedge when mem_we=1
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final write is accepted
err_ovf  output  1  sticky: pointer dropped because the buffer was full

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err_ovf=0.
  - count=0, weight reg=0, write index=0. Buffer contents are don't-care.
  - rst overrides every other input, including mid-write; any pending write is abandoned.
- Counters: count is clog2(D+1) bits (4 bits for D=8), saturating at D. Write index has the same width.
- FSM states: IDLE, COLLECT, WR_HDR, WR_CNT, WR_PATH, FIN.
- IDLE:
  - start=1: latch wpathmin; count=0; clear err_ovf; go to COLLECT.
  - node_vld and node_last are ignored.
- COLLECT, node_vld=1:
  - If count<D: buf[count]=node_ptr; count+1.
  - Else: pointer dropped; err_ovf=1.
- COLLECT, node_last=1 (with or without node_vld): the same-cycle pointer is stored first, then go to WR_HDR next cycle.
  - node_last with node_vld=0 and count=0 is an empty path (count 0).
- start is ignored while busy.
- WR_HDR: mem_we=1, mem_addr=BASE, mem_wdata=weight zero-extended to AW.
- WR_CNT: mem_addr=BASE+1, mem_wdata=count zero-extended.
  - When accepted: if count=0 go to FIN, else go to WR_PATH with index=0.
- WR_PATH: mem_addr=BASE+2+index, mem_wdata=buf[index].
  - On accept: if index=count-1 go to FIN, else index+1.
- Handshake, all write states:
  - A write completes at a posedge with mem_we=1 and mem_ready=1.
  - mem_addr and mem_wdata stay stable while mem_we=1 and mem_ready=0.
  - The next write is presented in the cycle immediately after acceptance, with no bubble. Back-to-back writes are therefore possible when mem_ready is held high.
- FIN: mem_we=0; done=1 for exactly one cycle; go to IDLE. busy=0 from that same next cycle.
- Latency with mem_ready held at 1, N pointers:
  - mem_we is high for N+2 consecutive cycles starting the cycle after node_last.
  - done rises one cycle after the last write is accepted.
- Address arithmetic: BASE+2+index is computed modulo 2^AW (wraps; no error).
- A weight of all-ones (2^WW-1) means no path was found. It is written unchanged; the block does not special-case it.
- err_ovf stays high until the next accepted start or reset. count stays at D.

Test Plan:
1. Reset, start with wpathmin=15'd37, pointers 5,12,40 (last on 40), mem_ready=1 → writes (0,37),(1,3),(2,5),(3,12),(4,40) on consecutive cycles; done one cycle later; busy low after.
2. Same stream, mem_ready toggling 0,1 each cycle → same five writes in order; addr/data stable during every stall; no write duplicated or lost.
3. Empty path: start with wpathmin=15'h7FFF, then node_last alone → writes (0,0x7FFF),(1,0); done; no WR_PATH cycles.
4. Overflow: 10 pointers (1..10) with last on 10, D=8 → err_ovf=1 on the 9th; writes count=8 and pointers 1..8; the next start clears err_ovf.
5. Second start pulse during COLLECT and during WR_PATH → ignored; latched weight unchanged.
6. rst asserted mid-WR_PATH with mem_ready=0 → next cycle mem_we=0, busy=0, done=0; a fresh run afterwards behaves as in scenario 1.
